// File: rtl/pc_pkg.sv
// Shared program-counter definitions for the control unit and pc_stack_unit.
// Holds default sizing and the PC operation encoding.
package pc_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int DEPTH_DEF = 8;
    localparam int RESET_VEC_DEF = 0;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_JUMP,
        PC_CALL,
        PC_RET
    } pc_op_e;

endpackage

// File: rtl/pc_stack_unit_ret_stack.sv
// Return-address LIFO with depth count, full/empty and push/pop.
// Build option PC_STACK_WRAP_EN: circular storage, push when full drops oldest.
module ret_stack
    import pc_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [PC_W-1:0]            push_data,
    output logic [PC_W-1:0]            top_data,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);

`ifdef PC_STACK_WRAP_EN
    // Top pointer runs modulo DEPTH, independent of the count.
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_inc;
    logic [AW-1:0] ptr_dec;

    assign ptr_inc = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign ptr_dec = (ptr == '0) ? AW'(DEPTH - 1) : ptr - 1'b1;
    assign wr_idx  = ptr;
    assign rd_idx  = ptr_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= ptr_inc;
        end else if (pop) begin
            ptr <= ptr_dec;
        end
    end
`else
    assign wr_idx = AW'(depth);
    assign rd_idx = AW'(depth - 1'b1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (push) begin
            if (!full) begin
                depth <= depth + 1'b1;
            end
        end else if (pop) begin
            depth <= depth - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    assign top_data = mem[rd_idx];

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack, stall and sticky ovf/unf flags.
// Build option PC_STACK_WRAP_EN: call on a full stack overwrites the oldest entry.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              DEPTH     = DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       s_inc,
    input  logic [PC_W-1:0]            jump_target,
    input  logic                       call,
    input  logic                       ret,
    output logic [PC_W-1:0]            pc,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       ovf,
    output logic                       unf
);

`ifdef PC_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    pc_op_e          op;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] top_data;
    logic            push;
    logic            pop;

    always_comb begin
        op = PC_JUMP;
        if (stall) begin
            op = PC_HOLD;
        end else if (ret) begin
            op = PC_RET;
        end else if (call) begin
            op = PC_CALL;
        end else if (s_inc) begin
            op = PC_INC;
        end
    end

    assign pc_inc = pc + 1'b1;
    assign push   = !reset && (op == PC_CALL)
                    && (!stack_full || WRAP);
    assign pop    = !reset && (op == PC_RET) && !stack_empty;

    ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_VEC;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            unique case (op)
                PC_HOLD: ;
                PC_RET: begin
                    if (stack_empty) begin
                        pc  <= pc_inc;
                        unf <= 1'b1;
                    end else begin
                        pc <= top_data;
                    end
                end
                PC_CALL: begin
                    if (stack_full) begin
                        ovf <= 1'b1;
                    end
                    // Without wrap a full-stack call falls through.
                    pc <= (stack_full && !WRAP) ? pc_inc : jump_target;
                end
                PC_INC:  pc <= pc_inc;
                PC_JUMP: pc <= jump_target;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: directed plan plus random traffic.
// Reference model keeps the return stack as a plain queue.
module tb_pc_stack_unit;

    localparam int              PC_W  = 10;
    localparam int              DEPTH = 3;
    localparam int              DW    = $clog2(DEPTH + 1);
    localparam logic [PC_W-1:0] RV    = 10'h040;

    typedef struct {
        logic [PC_W-1:0] pc;
        int              depth;
        logic            full;
        logic            empty;
        logic            ovf;
        logic            unf;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            stall = 1'b0;
    logic            s_inc = 1'b1;
    logic [PC_W-1:0] jump_target = '0;
    logic            call = 1'b0;
    logic            ret = 1'b0;
    logic [PC_W-1:0] pc;
    logic [DW-1:0]   depth;
    logic            stack_full;
    logic            stack_empty;
    logic            ovf;
    logic            unf;

    pc_stack_unit #(
        .PC_W      (PC_W),
        .DEPTH     (DEPTH),
        .RESET_VEC (RV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .s_inc       (s_inc),
        .jump_target (jump_target),
        .call        (call),
        .ret         (ret),
        .pc          (pc),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_stk [$];
    logic            m_ovf;
    logic            m_unf;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h",
                     name, step_id, act, req);
        end
    endtask

    // Monitor: one expected state per clock edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            step_id++;
            check("pc", int'(pc), int'(e.pc));
            check("depth", int'(depth), e.depth);
            check("full", int'(stack_full), int'(e.full));
            check("empty", int'(stack_empty), int'(e.empty));
            check("ovf", int'(ovf), int'(e.ovf));
            check("unf", int'(unf), int'(e.unf));
        end
    end

    task automatic model_step();
        logic [PC_W-1:0] nxt;
        exp_t e;
        nxt = m_pc + 1'b1;
        if (reset) begin
            m_pc = RV;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_pc  = nxt;
                m_unf = 1'b1;
            end
        end else if (call) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(nxt);
                m_pc = jump_target;
            end else begin
                m_ovf = 1'b1;
`ifdef PC_STACK_WRAP_EN
                void'(m_stk.pop_front());
                m_stk.push_back(nxt);
                m_pc = jump_target;
`else
                m_pc = nxt;
`endif
            end
        end else if (s_inc) begin
            m_pc = nxt;
        end else begin
            m_pc = jump_target;
        end
        e.pc    = m_pc;
        e.depth = m_stk.size();
        e.full  = (m_stk.size() == DEPTH);
        e.empty = (m_stk.size() == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
    endtask

    // Drive at negedge, then record expected result of the next posedge.
    task automatic drive(input logic r, input logic st,
                         input logic si, input logic c,
                         input logic rt, input logic [PC_W-1:0] jt);
        @(negedge clk);
        reset       = r;
        stall       = st;
        s_inc       = si;
        call        = c;
        ret         = rt;
        jump_target = jt;
        model_step();
    endtask

    task automatic rst1();
        drive(1, 0, 1, 0, 0, '0);
    endtask
    task automatic inc();
        drive(0, 0, 1, 0, 0, '0);
    endtask
    task automatic jmp(input logic [PC_W-1:0] t);
        drive(0, 0, 0, 0, 0, t);
    endtask
    task automatic do_call(input logic [PC_W-1:0] t);
        drive(0, 0, 1, 1, 0, t);
    endtask
    task automatic do_ret();
        drive(0, 0, 1, 0, 1, 10'h155);
    endtask

    initial begin
        int budget;
        m_pc  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        // Reset vector and increment
        rst1();
        rst1();
        repeat (3) inc();

        // Nested call / return
        jmp(10'h010);
        do_call(10'h100);
        do_call(10'h200);
        do_ret();
        do_ret();

        // Overflow on a full stack, then drain
        repeat (DEPTH + 1) do_call(10'h300);
        repeat (DEPTH) do_ret();

        // Underflow with pc wrap; unf sticky
        rst1();
        jmp(10'h3FF);
        do_ret();
        repeat (2) inc();
        jmp(10'h123);

        // Stall beats call; ret beats call
        rst1();
        jmp(10'h054);
        do_call(10'h2AA);
        drive(0, 1, 1, 1, 0, 10'h0F0);
        drive(0, 1, 0, 0, 1, 10'h0F0);
        drive(0, 0, 1, 1, 1, 10'h0F0);

        // Reset during a call with a full-ish stack
        repeat (3) do_call(10'h200);
        drive(1, 0, 1, 1, 0, 10'h0AA);
        inc();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, st, si, c, rt;
            r  = ($urandom_range(0, 99) == 0);
            st = ($urandom_range(0, 7) == 0);
            si = ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 3) == 0);
            rt = ($urandom_range(0, 3) == 0);
            drive(r, st, si, c, rt, PC_W'($urandom));
        end

        @(negedge clk);
        reset = 1'b0;
        stall = 1'b1;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
